// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic MAC array front end.
//   feeder_state_t : systolic_feeder FSM states
//   cnt_width()    : width of the feeder counters, clog2(3N)
//   stream_len()   : number of STREAM cycles for an N x N array, 3N-2
package tpu_pkg;

    localparam int unsigned N_DEFAULT        = 16;
    localparam int unsigned OP_WIDTH_DEFAULT = 8;
    localparam int unsigned STREAM_LEN       = 3 * N_DEFAULT - 2;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StClear,
        StStream,
        StDrain,
        StDone
    } feeder_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (3 * n > 1) ? $clog2(3 * n) : 1;
    endfunction

    function automatic int unsigned stream_len(input int unsigned n);
        return 3 * n - 2;
    endfunction

endpackage

// File: rtl/operand_skew_buffer.sv
// N x N operand store with a diagonally skewed read port.
//   clk    : clock, rising edge
//   wr_en  : write load vector wr_vec as slice wr_k
//   wr_k   : slice index k
//   wr_vec : lane l at [l*OP_WIDTH +: OP_WIDTH]
//   rd_t   : stream cycle index t
//   rd_vec : lane l = element written as lane l of slice t-l, or 0 if t-l is out of range
// TRANSPOSE only changes the storage layout (lane-major vs slice-major); the
// values seen on rd_vec are identical either way.
module operand_skew_buffer
    import tpu_pkg::*;
#(
    parameter int unsigned N         = N_DEFAULT,
    parameter int unsigned OP_WIDTH  = OP_WIDTH_DEFAULT,
    parameter bit          TRANSPOSE = 1'b0,
    parameter int unsigned CW        = cnt_width(N),
    localparam int unsigned IW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [IW-1:0]         wr_k,
    input  logic [N*OP_WIDTH-1:0] wr_vec,
    input  logic [CW-1:0]         rd_t,
    output logic [N*OP_WIDTH-1:0] rd_vec
);

    logic [OP_WIDTH-1:0] mem [N][N];

    // Matrix contents are always fully rewritten before use, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < N; l++) begin
                if (TRANSPOSE) begin
                    mem[l][wr_k] <= wr_vec[l*OP_WIDTH +: OP_WIDTH];
                end else begin
                    mem[wr_k][l] <= wr_vec[l*OP_WIDTH +: OP_WIDTH];
                end
            end
        end
    end

    always_comb begin
        int d;
        d      = 0;
        rd_vec = '0;
        for (int l = 0; l < N; l++) begin
            d = int'(rd_t) - l;
            if (d >= 0 && d < int'(N)) begin
                rd_vec[l*OP_WIDTH +: OP_WIDTH] = TRANSPOSE ? mem[l][d[IW-1:0]]
                                                           : mem[d[IW-1:0]][l];
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Transmit side of the N x N systolic MAC array: loads A and B one k-slice per
// beat, clears the array, streams skewed operand vectors for 3N-2 cycles, waits
// MAC_LATENCY cycles for the pipeline to drain, then flags the result.
//   clk, reset             : clock, asynchronous active-high reset
//   load_valid/load_ready  : load handshake; beat k carries A[*][k] and B[k][*]
//   load_a_col, load_b_row : element i/j at [i*OP_WIDTH +: OP_WIDTH]
//   array_clear            : one-cycle clear pulse to the array accumulators
//   new_a_column, new_b_row: registered skewed operand vectors
//   result_valid/ready     : accumulators hold C = A x B until result_ready
module systolic_feeder
    import tpu_pkg::*;
#(
    parameter int unsigned N           = N_DEFAULT,
    parameter int unsigned OP_WIDTH    = OP_WIDTH_DEFAULT,
    parameter int unsigned MAC_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [N*OP_WIDTH-1:0] load_a_col,
    input  logic [N*OP_WIDTH-1:0] load_b_row,
    output logic                  array_clear,
    output logic [N*OP_WIDTH-1:0] new_a_column,
    output logic [N*OP_WIDTH-1:0] new_b_row,
    output logic                  result_valid,
    input  logic                  result_ready
);

    localparam int unsigned CW = cnt_width(N);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned T  = stream_len(N);
    localparam int unsigned DW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

    localparam logic [CW-1:0] LAST_BEAT  = CW'(N - 1);
    localparam logic [CW-1:0] LAST_T     = CW'(T - 1);
    localparam logic [DW-1:0] LAST_DRAIN = (MAC_LATENCY > 0) ? DW'(MAC_LATENCY - 1) : '0;

    feeder_state_t state_q, state_d;
    logic [CW-1:0] beat_q, beat_d;
    logic [CW-1:0] t_q, t_d;
    logic [DW-1:0] drain_q, drain_d;

    logic                  accept;
    logic [N*OP_WIDTH-1:0] skew_a, skew_b;

    assign accept = load_valid && load_ready;

    operand_skew_buffer #(
        .N         (N),
        .OP_WIDTH  (OP_WIDTH),
        .TRANSPOSE (1'b1),
        .CW        (CW)
    ) u_buf_a (
        .clk    (clk),
        .wr_en  (accept),
        .wr_k   (beat_q[IW-1:0]),
        .wr_vec (load_a_col),
        .rd_t   (t_d),
        .rd_vec (skew_a)
    );

    operand_skew_buffer #(
        .N         (N),
        .OP_WIDTH  (OP_WIDTH),
        .TRANSPOSE (1'b0),
        .CW        (CW)
    ) u_buf_b (
        .clk    (clk),
        .wr_en  (accept),
        .wr_k   (beat_q[IW-1:0]),
        .wr_vec (load_b_row),
        .rd_t   (t_d),
        .rd_vec (skew_b)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        t_d     = t_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (N == 1) begin
                        state_d = StClear;
                        beat_d  = '0;
                    end else begin
                        state_d = StLoad;
                        beat_d  = CW'(1);
                    end
                end
            end
            StLoad: begin
                if (accept) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = StClear;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StClear: begin
                state_d = StStream;
                t_d     = '0;
            end
            StStream: begin
                if (t_q == LAST_T) begin
                    t_d     = '0;
                    drain_d = '0;
                    state_d = (MAC_LATENCY == 0) ? StDone : StDrain;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = StDone;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StDone: begin
                if (result_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state, so the vector for stream
    // cycle t is read with t_d and appears during that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            beat_q       <= '0;
            t_q          <= '0;
            drain_q      <= '0;
            load_ready   <= 1'b0;
            array_clear  <= 1'b0;
            new_a_column <= '0;
            new_b_row    <= '0;
            result_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            t_q          <= t_d;
            drain_q      <= drain_d;
            load_ready   <= (state_d == StIdle) || (state_d == StLoad);
            array_clear  <= (state_d == StClear);
            new_a_column <= (state_d == StStream) ? skew_a : '0;
            new_b_row    <= (state_d == StStream) ? skew_b : '0;
            result_valid <= (state_d == StDone);
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: an N=4/MAC_LATENCY=1 instance under
// randomized jobs against a matrix-level model, and an N=2/MAC_LATENCY=3
// instance under the directed 2x2 example.
module tb_systolic_feeder;

    localparam int N   = 4;
    localparam int OPW = 8;
    localparam int LAT = 1;
    localparam int T   = 3 * N - 2;
    localparam int W   = N * OPW;

    localparam int N2   = 2;
    localparam int LAT2 = 3;
    localparam int T2   = 3 * N2 - 2;
    localparam int W2   = N2 * OPW;

    localparam logic [W2-1:0] EA2 [T2] = '{16'h0001, 16'h0302, 16'h0400, 16'h0000};
    localparam logic [W2-1:0] EB2 [T2] = '{16'h0005, 16'h0607, 16'h0800, 16'h0000};

    logic clk = 1'b0;
    logic reset;

    logic         load_valid, load_ready, array_clear, result_valid, result_ready;
    logic [W-1:0] load_a_col, load_b_row, new_a_column, new_b_row;

    logic          l2_valid, l2_ready, l2_clear, l2_rv, l2_rr;
    logic [W2-1:0] l2_a, l2_b, l2_na, l2_nb;

    int n_checks = 0;
    int n_errors = 0;

    int ma [N][N];
    int mb [N][N];
    int av [T][N];
    int bv [T][N];

    always #5 clk = ~clk;

    systolic_feeder #(
        .N           (N),
        .OP_WIDTH    (OPW),
        .MAC_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_a_col   (load_a_col),
        .load_b_row   (load_b_row),
        .array_clear  (array_clear),
        .new_a_column (new_a_column),
        .new_b_row    (new_b_row),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    systolic_feeder #(
        .N           (N2),
        .OP_WIDTH    (OPW),
        .MAC_LATENCY (LAT2)
    ) dut2 (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (l2_valid),
        .load_ready   (l2_ready),
        .load_a_col   (l2_a),
        .load_b_row   (l2_b),
        .array_clear  (l2_clear),
        .new_a_column (l2_na),
        .new_b_row    (l2_nb),
        .result_valid (l2_rv),
        .result_ready (l2_rr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_a(input int t);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[i*OPW +: OPW] = OPW'(ma[i][t-i]);
        return v;
    endfunction

    function automatic logic [W-1:0] exp_b(input int t);
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[j*OPW +: OPW] = OPW'(mb[t-j][j]);
        return v;
    endfunction

    task automatic fill(input bit ident);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = ident ? ((i == j) ? 1 : 0) : int'($urandom_range(0, 255));
                mb[i][j] = ident ? (i * N + j + 1) : int'($urandom_range(0, 255));
            end
    endtask

    // Push recorded vectors through an ideal array (a moves right, b moves
    // down one MAC per cycle) and compare accumulators with A x B.
    task automatic check_product();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int acc;
                int prod;
                acc  = 0;
                prod = 0;
                for (int t = 0; t < T + LAT; t++)
                    if (t - j >= 0 && t - j < T && t - i >= 0 && t - i < T)
                        acc += av[t-j][i] * bv[t-i][j];
                for (int k = 0; k < N; k++) prod += ma[i][k] * mb[k][j];
                check("c_accum", 64'(acc), 64'(prod));
            end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_a"}, 64'(new_a_column), 64'(0));
        check({tag, "_b"}, 64'(new_b_row), 64'(0));
    endtask

    // Called just after a negedge with the DUT in IDLE; returns just after a
    // negedge with the DUT back in IDLE.
    task automatic run_job(input int hold, input bit force_first, input bit abort_at2);
        int k;
        int guard;
        k     = 0;
        guard = 0;
        while (k < N && guard < 400) begin
            bit v;
            check("load_ready", 64'(load_ready), 64'(1));
            check("load_clear", 64'(array_clear), 64'(0));
            check_quiet("load_vec");
            v = (k == 0 && force_first) ? 1'b1 : 1'($urandom_range(0, 1));
            load_valid = v;
            if (v) begin
                for (int i = 0; i < N; i++) begin
                    load_a_col[i*OPW +: OPW] = OPW'(ma[i][k]);
                    load_b_row[i*OPW +: OPW] = OPW'(mb[k][i]);
                end
            end else begin
                load_a_col = $urandom;
                load_b_row = $urandom;
            end
            result_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (v) k++;
            guard++;
        end
        if (k < N) check("load_bound", 64'(k), 64'(N));

        load_valid = 1'($urandom_range(0, 1));
        load_a_col = $urandom;
        load_b_row = $urandom;
        check("clear", 64'(array_clear), 64'(1));
        check("clear_ready", 64'(load_ready), 64'(0));
        check("clear_rv", 64'(result_valid), 64'(0));
        check_quiet("clear_vec");
        @(negedge clk);

        for (int t = 0; t < T; t++) begin
            check("stream_a", 64'(new_a_column), 64'(exp_a(t)));
            check("stream_b", 64'(new_b_row), 64'(exp_b(t)));
            check("stream_ready", 64'(load_ready), 64'(0));
            check("stream_clear", 64'(array_clear), 64'(0));
            check("stream_rv", 64'(result_valid), 64'(0));
            for (int i = 0; i < N; i++) begin
                av[t][i] = int'(new_a_column[i*OPW +: OPW]);
                bv[t][i] = int'(new_b_row[i*OPW +: OPW]);
            end
            if (abort_at2 && t == 2) begin
                reset = 1'b1;
                #1;
                check("rst_ready", 64'(load_ready), 64'(0));
                check("rst_clear", 64'(array_clear), 64'(0));
                check("rst_rv", 64'(result_valid), 64'(0));
                check_quiet("rst_vec");
                @(negedge clk);
                reset        = 1'b0;
                load_valid   = 1'b0;
                result_ready = 1'b0;
                @(negedge clk);
                check("rst_then_ready", 64'(load_ready), 64'(1));
                check("rst_then_clear", 64'(array_clear), 64'(0));
                return;
            end
            load_valid   = 1'($urandom_range(0, 1));
            result_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end

        for (int d = 0; d < LAT; d++) begin
            check("drain_rv", 64'(result_valid), 64'(0));
            check("drain_ready", 64'(load_ready), 64'(0));
            check_quiet("drain_vec");
            @(negedge clk);
        end

        load_valid = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            check("done_rv", 64'(result_valid), 64'(1));
            check("done_ready", 64'(load_ready), 64'(0));
            check_quiet("done_vec");
            result_ready = (h == hold);
            load_valid   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        load_valid   = 1'b0;
        result_ready = 1'b0;
        check("exit_rv", 64'(result_valid), 64'(0));
        check("exit_ready", 64'(load_ready), 64'(1));
        check_product();
    endtask

    task automatic run_n2();
        int oa [T2][N2];
        int ob [T2][N2];
        int c2 [N2][N2];
        c2 = '{'{19, 22}, '{43, 50}};
        check("n2_ready", 64'(l2_ready), 64'(1));
        l2_valid = 1'b1;
        l2_a     = 16'h0301;
        l2_b     = 16'h0605;
        @(negedge clk);
        check("n2_ready1", 64'(l2_ready), 64'(1));
        l2_a = 16'h0402;
        l2_b = 16'h0807;
        @(negedge clk);
        l2_valid = 1'b0;
        check("n2_clear", 64'(l2_clear), 64'(1));
        check("n2_clear_ready", 64'(l2_ready), 64'(0));
        @(negedge clk);
        for (int t = 0; t < T2; t++) begin
            check("n2_a", 64'(l2_na), 64'(EA2[t]));
            check("n2_b", 64'(l2_nb), 64'(EB2[t]));
            check("n2_stream_clear", 64'(l2_clear), 64'(0));
            for (int i = 0; i < N2; i++) begin
                oa[t][i] = int'(l2_na[i*OPW +: OPW]);
                ob[t][i] = int'(l2_nb[i*OPW +: OPW]);
            end
            @(negedge clk);
        end
        for (int d = 0; d < LAT2; d++) begin
            check("n2_drain_rv", 64'(l2_rv), 64'(0));
            check("n2_drain_a", 64'(l2_na), 64'(0));
            @(negedge clk);
        end
        check("n2_done_rv", 64'(l2_rv), 64'(1));
        l2_rr = 1'b1;
        @(negedge clk);
        l2_rr = 1'b0;
        check("n2_exit_rv", 64'(l2_rv), 64'(0));
        check("n2_exit_ready", 64'(l2_ready), 64'(1));
        for (int i = 0; i < N2; i++)
            for (int j = 0; j < N2; j++) begin
                int acc;
                acc = 0;
                for (int t = 0; t < T2 + LAT2; t++)
                    if (t - j >= 0 && t - j < T2 && t - i >= 0 && t - i < T2)
                        acc += oa[t-j][i] * ob[t-i][j];
                check("n2_c", 64'(acc), 64'(c2[i][j]));
            end
    endtask

    initial begin
        reset        = 1'b1;
        load_valid   = 1'b0;
        result_ready = 1'b0;
        load_a_col   = '0;
        load_b_row   = '0;
        l2_valid     = 1'b0;
        l2_rr        = 1'b0;
        l2_a         = '0;
        l2_b         = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", 64'(load_ready), 64'(0));
        check("reset_clear", 64'(array_clear), 64'(0));
        check("reset_rv", 64'(result_valid), 64'(0));
        check_quiet("reset_vec");
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(load_ready), 64'(1));

        fill(1'b1);
        run_job(10, 1'b0, 1'b0);
        fill(1'b0);
        run_job(0, 1'b1, 1'b0);
        fill(1'b0);
        run_job(0, 1'b0, 1'b1);
        fill(1'b0);
        run_job(2, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            fill(1'b0);
            run_job(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0);
        end

        run_n2();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors",
                 n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
